decoder_scan_n: RTL
===================

Name: decoder_scan_n

Overview:
- Parametrised registered N-to-2^N one-hot decoder; generalises the fixed 3-to-8 combinational decoder.
- Two modes:
  - DIRECT: registers the decode of an external select.
  - SCAN: an internal index counter walks the outputs with a programmable dwell time.
- Drives digit/row enables for multiplexed displays and channel strobes elsewhere in the lab designs.

Parameters:
- SEL_W, 3, select width; OUT_W = 2**SEL_W output lines (8 by default).
- DWELL_W, 8, width of dwell count (cycles per scan step, minus one).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low forces outputs off.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- in_valid  input  1  DIRECT only: sample in_sel this cycle.
- in_sel  input  SEL_W  DIRECT select value.
- dwell  input  DWELL_W  SCAN: cycles per index = dwell+1.
- out  output  OUT_W  registered one-hot decode.
- out_valid  output  1  out holds a valid one-hot code.
- scan_idx  output  SEL_W  current scan index (0 outside SCAN).
- wrap  output  1  one-cycle pulse when the scan index wraps to its lowest position.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out=0, out_valid=0, scan_idx=0, wrap=0, dwell counter cnt=0.
- States: IDLE, DIRECT, SCAN. All outputs are registered; every latency below is 1 clock from the sampling edge.
- Any state, en=0 at an edge: next state IDLE; out=0, out_valid=0, scan_idx=0, cnt=0, wrap=0.
- en=1, mode=0: next state DIRECT.
  - in_valid=1: out <= 1<<in_sel, out_valid <= 1.
  - in_valid=0: out and out_valid hold.
  - Entering DIRECT from IDLE or SCAN: out=0, out_valid=0 until the first in_valid.
- en=1, mode=1, state!=SCAN: enter SCAN; scan_idx <= 0, out <= 1, out_valid <= 1, cnt <= 0, wrap <= 0.
- In SCAN:
  - cnt!=dwell: cnt++, outputs hold.
  - cnt==dwell: cnt <= 0, scan_idx <= scan_idx+1 (mod OUT_W), out <= one-hot of the new index.
  - wrap <= 1 when scan_idx goes OUT_W-1 -> 0; otherwise wrap <= 0.
  - in_valid and in_sel are ignored.
- dwell=0: index advances every cycle.
- dwell changes mid-step are compared live, so a new value takes effect immediately. If cnt > new dwell, cnt counts up and wraps modulo 2^DWELL_W before matching.
- Mode switch SCAN -> DIRECT: out cleared, scan_idx cleared, next cycle.
- Invariant: out is zero or exactly one-hot, never multi-hot.

Optional Feature:
- Macro DECODER_SCAN_MASK_EN adds input port mask [OUT_W-1:0]; a 1 bit skips that line.
- With the macro defined:
  - SCAN: each advance goes to the next unmasked index cyclically. Entering SCAN selects the lowest unmasked index.
  - wrap pulses when the new index is numerically <= the old index.
  - All lines masked: out=0, out_valid=0, scan_idx held, cnt held.
  - DIRECT: in_valid with a masked in_sel gives out=0, out_valid=0.
  - Mask changes are sampled at each advance.
- Without the macro: no mask port; all lines are always eligible. Behaviour is exactly as above.

Test Plan:
- Reset then DIRECT sweep: rst_n low 3 cycles -> out=0, out_valid=0. en=1, mode=0, in_valid=1, in_sel=0..7, one per cycle -> one cycle later out=8'h01,8'h02,...,8'h80 and out_valid=1. in_valid=0 -> out holds 8'h80.
- SCAN with dwell=2: each index lasts 3 cycles. out=8'h01 x3, 8'h02 x3 ... 8'h80 x3, then 8'h01 with wrap=1 for exactly 1 cycle. Period is 24 cycles.
- SCAN with dwell=0: out shifts every cycle; wrap pulses every 8 cycles; in_valid/in_sel toggling has no effect.
- Enable and reset mid-scan: en=0 at scan_idx=5 -> next cycle out=0, scan_idx=0. en=1 again -> restart at out=8'h01. rst_n asserted mid-step -> outputs 0 immediately, without waiting for a clock edge.
- Mode switch: SCAN at index 3, then mode=0 -> out=0, out_valid=0. in_valid with in_sel=6 -> out=8'h40.
- DECODER_SCAN_MASK_EN with mask=8'b0110_1101, dwell=0:
  - SCAN visits 1, 4, 7, then 1 with wrap on the 7->1 step.
  - mask=8'hFF -> out=0, out_valid=0.
  - DIRECT with in_sel=2 and mask bit 2 set -> out=0.

Source files
------------

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2^N one-hot decoder with DIRECT and SCAN modes
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   en                  block enable; low clears all outputs
//   mode                0 = DIRECT (decode in_sel), 1 = SCAN (walk outputs)
//   in_valid, in_sel    DIRECT select strobe and value
//   dwell               SCAN: cycles per index minus one, compared live
//   mask                (only with DECODER_SCAN_MASK_EN) 1 bit skips that line
//   out, out_valid      registered one-hot code and its valid flag
//   scan_idx            current scan index, 0 outside SCAN
//   wrap                one-cycle pulse when the scan index wraps
// Optional feature macro: DECODER_SCAN_MASK_EN
module decoder_scan_n #(
    parameter int SEL_W = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [OUT_W-1:0]   mask,
`endif
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   scan_idx,
    output logic               wrap
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d, elig;
    logic out_valid_q, out_valid_d, wrap_q, wrap_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d, next_idx, first_idx;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
`ifdef DECODER_SCAN_MASK_EN
    assign elig = ~mask;
`else
    assign elig = '1;
`endif
    // Cyclic search from idx+1; descending k leaves the nearest eligible line,
    // and k = OUT_W lands back on the current index when it is the only one.
    always_comb begin
        next_idx = scan_idx_q;
        for (int k = OUT_W; k >= 1; k--)
            if (elig[scan_idx_q + SEL_W'(k)]) next_idx = scan_idx_q + SEL_W'(k);
    end
    always_comb begin
        first_idx = '0;
        for (int i = OUT_W - 1; i >= 0; i--)
            if (elig[i]) first_idx = SEL_W'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        scan_idx_d  = scan_idx_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        if (!en) begin
            out_d       = '0;
            out_valid_d = 1'b0;
            scan_idx_d  = '0;
            cnt_d       = '0;
        end else if (!mode) begin
            scan_idx_d = '0;
            cnt_d      = '0;
            if (in_valid) begin
                out_valid_d = elig[in_sel];
                out_d       = elig[in_sel] ? OUT_W'(1) << in_sel : '0;
            end else if (state_q != DIRECT) begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        end else if (state_q != SCAN) begin
            scan_idx_d  = first_idx;
            cnt_d       = '0;
            out_valid_d = |elig;
            out_d       = |elig ? OUT_W'(1) << first_idx : '0;
        end else if (~|elig) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (cnt_q != dwell) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d       = '0;
            scan_idx_d  = next_idx;
            out_d       = OUT_W'(1) << next_idx;
            out_valid_d = 1'b1;
            wrap_d      = next_idx <= scan_idx_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_idx_q  <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            scan_idx_q  <= scan_idx_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
        end
    end
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign scan_idx  = scan_idx_q;
    assign wrap      = wrap_q;
endmodule
